sobel_line_filter: RTL
======================

// Module: sobel_line_filter
// PURPOSE
// Streaming 3x3 Sobel edge stage.
// - Consumes greyscale pixels in raster order from the SRAM pixel read path (8-bit pixels).
// - Produces the gradient magnitude and an edge flag for every interior pixel.
// - Results feed the SRAM write-back path.
// - Two on-chip line buffers hold the previous rows, so every input pixel is fetched exactly once.
// PARAMETERS
// BIT_PER_PIXEL  8    greyscale pixel width
// IMG_WIDTH      16   pixels per row, >= 3
// IMG_HEIGHT     16   rows per frame, >= 3
// THRESHOLD      64   edge_bit asserts when magnitude >= THRESHOLD
// PORTS
// clk           in   1              system clock, rising edge
// n_rst         in   1              asynchronous active-low reset
// start         in   1              one-cycle pulse: begin a frame (honoured only in IDLE)
// pix_in        in   BIT_PER_PIXEL  greyscale input pixel
// pix_in_valid  in   1              pix_in holds a valid pixel
// pix_in_ready  out  1              block accepts pix_in this cycle
// edge_out      out  BIT_PER_PIXEL  saturated |Gx|+|Gy|
// edge_bit      out  1              edge_out >= THRESHOLD (compared on the unsaturated sum)
// edge_valid    out  1              edge_out / edge_bit are valid
// edge_ready    in   1              consumer takes the output this cycle
// busy          out  1              state != IDLE
// frame_done    out  1              one-cycle pulse after the last output is taken
// BEHAVIOUR
// - Reset: state=IDLE, row=col=0, all outputs 0, window registers 0. Line-buffer contents are don't-care.
// - States and transitions:
//   - IDLE -> RUN on start.
//   - RUN -> DONE when the last pixel (row H-1, col W-1) has been accepted and edge_valid==0 (its output has been taken).
//   - DONE -> IDLE unconditionally; frame_done=1 only in DONE.
// - Accept rule: pix_in_ready = (state==RUN) && !last_accepted && (!edge_valid || edge_ready). A pixel is accepted on the cycle pix_in_valid && pix_in_ready.
// - On each accept:
//   - Window shifts left one column.
//   - New right column = {lbuf1[col], lbuf0[col], pix_in}, oldest row first.
//   - lbuf1[col] <= lbuf0[col]; lbuf0[col] <= pix_in.
//   - col increments. At W-1, col wraps to 0 and row increments.
// - Output generation: an output is produced iff the accepted pixel has row>=2 && col>=2; it is the result for centre pixel (row-1, col-1).
//   - Latency: edge_valid=1 on the cycle after the accept.
//   - Result count per frame: (W-2)*(H-2). Border pixels produce no output.
// - Output handshake:
//   - edge_valid holds, and edge_out/edge_bit stay stable, until edge_ready.
//   - edge_valid clears on edge_ready unless a new output loads in the same cycle (full throughput of 1 pixel/clk).
// - Arithmetic, window w[r][c] with r,c in 0..2 and r=0 the oldest row:
//   - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20), signed 11 bits.
//   - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02), signed 11 bits.
//   - mag = |Gx| + |Gy|, 11 bits unsigned, max 2040. edge_out = min(mag, 255).
// - Row wrap: window columns still hold the previous row's tail at col 0/1. These are never output because of the col>=2 gate.
// - start while busy: ignored. pix_in_valid in IDLE/DONE: ignored, ready=0.
// - Reset mid-frame: immediate return to reset state. The next frame needs a new start and is processed with no residue from the aborted frame.
// TESTING
// 1. Uniform frame, all pixels 8'd50 -> 196 outputs (16x16), all edge_out=0, edge_bit=0; frame_done pulses once.
// 2. Vertical step, col<8 =0 and col>=8 =100 -> centre cols 7,8: Gx=400, edge_out=255, edge_bit=1; all other outputs 0.
// 3. Horizontal ramp pix=4*col -> every output edge_out=32, edge_bit=0.
// 4. Backpressure: drop edge_ready for 5 cycles mid-row -> edge_out stable, pix_in_ready=0, no output lost or duplicated; the total is still 196.
// 5. pix_in_valid toggling every other cycle -> identical output sequence to the continuous-stream case.
// 6. n_rst asserted at row 5, then start with a fresh step frame -> outputs match test 2 exactly; busy=0 during reset.

Source files
------------

// File: rtl/sobel_line_filter.sv
// Streaming 3x3 Sobel stage: raster-order greyscale in, saturated |Gx|+|Gy| plus
// an edge flag out for every interior pixel, using two line buffers for the previous rows.
module sobel_line_filter #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int IMG_WIDTH     = 16,
  parameter int IMG_HEIGHT    = 16,
  parameter int THRESHOLD     = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [BIT_PER_PIXEL-1:0] pix_in,
  input  logic                     pix_in_valid,
  output logic                     pix_in_ready,
  output logic [BIT_PER_PIXEL-1:0] edge_out,
  output logic                     edge_bit,
  output logic                     edge_valid,
  input  logic                     edge_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int SW = BIT_PER_PIXEL + 3;
  localparam logic [SW-1:0] PIX_MAX = SW'((1 << BIT_PER_PIXEL) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [CW-1:0]            col_reg, col_next;
  logic [RW-1:0]            row_reg, row_next;
  logic                     last_accepted_reg;
  logic                     accept, at_last_col, at_last_row, out_load;

  logic [BIT_PER_PIXEL-1:0] w_reg   [3][3];
  logic [BIT_PER_PIXEL-1:0] w_next  [3][3];
  logic [BIT_PER_PIXEL-1:0] new_col [3];
  logic [BIT_PER_PIXEL-1:0] lbuf0   [IMG_WIDTH];
  logic [BIT_PER_PIXEL-1:0] lbuf1   [IMG_WIDTH];
  logic [BIT_PER_PIXEL-1:0] lb0_rd_reg, lb1_rd_reg;

  logic [SW-1:0]            sum_r, sum_l, sum_b, sum_t, diff_x, diff_y, abs_x, abs_y, mag;
  logic [BIT_PER_PIXEL-1:0] edge_sat;
  logic [BIT_PER_PIXEL-1:0] edge_out_reg;
  logic                     edge_bit_reg, edge_valid_reg;

  // FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_accepted_reg && !edge_valid_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pix_in_ready = (state_reg == RUN) && !last_accepted_reg && (!edge_valid_reg || edge_ready);
    busy         = (state_reg != IDLE);
    frame_done   = (state_reg == DONE);
  end

  assign accept      = pix_in_valid && pix_in_ready;
  assign at_last_col = (col_reg == CW'(IMG_WIDTH - 1));
  assign at_last_row = (row_reg == RW'(IMG_HEIGHT - 1));
  assign out_load    = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      col_next = at_last_col ? '0 : col_reg + CW'(1);
      if (at_last_col) row_next = at_last_row ? '0 : row_reg + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_reg           <= '0;
      row_reg           <= '0;
      last_accepted_reg <= 1'b0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      if (state_reg != RUN)                        last_accepted_reg <= 1'b0;
      else if (accept && at_last_col && at_last_row) last_accepted_reg <= 1'b1;
    end
  end

  // Reads are prefetched at the column the next accept will use; the write
  // address is always the current column, so the two never collide.
  always_ff @(posedge clk) begin
    if (accept) begin
      lbuf1[col_reg] <= lb0_rd_reg;
      lbuf0[col_reg] <= pix_in;
    end
    lb0_rd_reg <= lbuf0[col_next];
    lb1_rd_reg <= lbuf1[col_next];
  end

  assign new_col[0] = lb1_rd_reg;
  assign new_col[1] = lb0_rd_reg;
  assign new_col[2] = pix_in;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
      assign w_next[gi][0] = w_reg[gi][1];
      assign w_next[gi][1] = w_reg[gi][2];
      assign w_next[gi][2] = new_col[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_reg[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_reg[r][c] <= w_next[r][c];
    end
  end

  // Gradient is taken on the window as it will look after this accept.
  always_comb begin
    sum_r  = SW'(w_next[0][2]) + (SW'(w_next[1][2]) << 1) + SW'(w_next[2][2]);
    sum_l  = SW'(w_next[0][0]) + (SW'(w_next[1][0]) << 1) + SW'(w_next[2][0]);
    sum_b  = SW'(w_next[2][0]) + (SW'(w_next[2][1]) << 1) + SW'(w_next[2][2]);
    sum_t  = SW'(w_next[0][0]) + (SW'(w_next[0][1]) << 1) + SW'(w_next[0][2]);
    diff_x = sum_r - sum_l;
    diff_y = sum_b - sum_t;
    abs_x  = diff_x[SW-1] ? (~diff_x + SW'(1)) : diff_x;
    abs_y  = diff_y[SW-1] ? (~diff_y + SW'(1)) : diff_y;
    mag    = abs_x + abs_y;
    edge_sat = (mag > PIX_MAX) ? '1 : mag[BIT_PER_PIXEL-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_out_reg   <= '0;
      edge_bit_reg   <= 1'b0;
      edge_valid_reg <= 1'b0;
    end else begin
      if (out_load) begin
        edge_out_reg <= edge_sat;
        edge_bit_reg <= (mag >= SW'(THRESHOLD));
      end
      if (out_load)        edge_valid_reg <= 1'b1;
      else if (edge_ready) edge_valid_reg <= 1'b0;
    end
  end

  assign edge_out   = edge_out_reg;
  assign edge_bit   = edge_bit_reg;
  assign edge_valid = edge_valid_reg;

endmodule
